icache_loader: RTL
==================

ICACHE_LOADER -- requirements
Module: icache_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, log2 of instruction-memory depth (DEPTH = 2**ADDR_W 16-bit words).
REQ-002 clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low; 0 = reset.
REQ-004 rx_data  input  8  received byte from UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-006 pc  input  16  program counter from control unit.
REQ-007 raw_instruction  output  16  instruction at pc; first-received byte in bits [15:8].
REQ-008 program_complete  input  1  core reports end of program.
REQ-009 core_run  output  1  high only while a verified program is loaded; core held frozen otherwise.
REQ-010 load_error  output  1  high in ERR state.
REQ-011 loaded_len  output  ADDR_W+1  number of valid instructions currently loaded.

Function
REQ-012 FSM states SHALL be SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, RUN, ERR; every transition except the two RUN exits SHALL require rx_valid=1.
REQ-013 SYNC: byte 0xC5 -> LEN_HI; any other byte ignored.
REQ-014 LEN_HI/LEN_LO: capture 16-bit length L (big-endian); at LEN_LO, L==0 or L>DEPTH -> ERR, else -> DATA_HI, word address cleared to 0, checksum cleared to 0x00.
REQ-015 DATA_HI: latch high byte -> DATA_LO; DATA_LO: write {hi,lo} to memory at word address, increment address -> DATA_HI, or -> CHK when incremented address == L.
REQ-016 Checksum SHALL be XOR of all data bytes (hi and lo); CHK byte equal -> RUN with loaded_len=L the same edge; unequal -> ERR.
REQ-017 loaded_len SHALL be forced to 0 on entry to LEN_HI so a partial load is never executable.
REQ-018 RUN: core_run=1 combinationally from state; rx bytes ignored; program_complete=1 -> SYNC, core_run=0 the following cycle; loaded_len retained so memory may be re-run only by reload.
REQ-019 Simultaneous rx_valid and program_complete in RUN: program_complete wins, byte discarded.
REQ-020 ERR: load_error=1; byte 0xC5 -> LEN_HI (clears load_error); other bytes ignored.
REQ-021 raw_instruction SHALL be combinational: mem[pc[ADDR_W-1:0]] when pc < loaded_len, else 16'h0000 (including pc >= DEPTH).
REQ-022 Memory writes SHALL occur only in DATA_LO with rx_valid; no write in any other state.
REQ-023 Address and length comparisons SHALL use ADDR_W+1 bits, no wrap; L==DEPTH is legal and fills memory exactly.

Reset
REQ-024 On reset=0: state=SYNC, core_run=0, load_error=0, loaded_len=0, address/checksum/length registers 0; effective immediately, independent of clk.
REQ-025 Memory contents SHALL NOT be cleared by reset; REQ-021 gating guarantees raw_instruction=0 after reset.
REQ-026 Reset asserted mid-load SHALL abandon the load; next load starts from SYNC.

Structure
REQ-027 Sync constant 0xC5 and the loader state enum SHALL live in the shared core package.
REQ-028 Instruction storage SHALL be a sub-module icache_mem (one sync write port, one async read port, DEPTH x 16); FSM, counters and checksum stay in icache_loader.

Verification
REQ-029 Bytes C5 00 02 12 34 AB CD (chk 0x12^0x34^0xAB^0xCD=0x40) 40 -> core_run=1 after last byte, loaded_len=2, pc=0 -> 0x1234, pc=1 -> 0xABCD, pc=2 -> 0x0000.
REQ-030 Same stream with checksum 0x41 -> load_error=1, core_run=0, loaded_len=0; then valid stream -> RUN, load_error=0.
REQ-031 C5 00 00 -> ERR; C5 04 01 with ADDR_W=10 -> ERR; C5 04 00 plus 1024 words plus chk -> RUN, loaded_len=1024.
REQ-032 In RUN, program_complete pulse coincident with rx_valid byte 0xC5 -> next cycle state SYNC, core_run=0, byte not taken as sync.
REQ-033 Assert reset=0 between two data bytes, asynchronously mid-cycle -> outputs zero before next clk edge; fresh full stream then loads correctly.
REQ-034 Noise bytes 00 FF 3C before C5 in SYNC -> ignored, load proceeds normally.

Source files
------------

// File: rtl/icache_loader_pkg.sv
// Shared definitions for the instruction-cache loader.
//   SYNC_BYTE      : frame start marker on the UART byte stream
//   loader_state_e : loader FSM state encoding
package icache_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hC5;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/icache_loader_mem.sv
// Instruction storage: DEPTH x 16 words, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : read data (combinational)
module icache_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/icache_loader.sv
// Loads a program into instruction memory from a UART byte stream and gates
// core execution on a verified load.
// Frame: C5, len_hi, len_lo, {hi, lo} x len words, xor checksum of data bytes.
//   clk              : system clock
//   reset            : asynchronous reset, active low
//   rx_data/rx_valid : received byte and its one-cycle strobe
//   pc               : program counter from the core
//   raw_instruction  : instruction at pc, zero outside the loaded range
//   program_complete : core reports end of program
//   core_run         : high while a verified program is loaded and running
//   load_error       : high while the loader sits in the error state
//   loaded_len       : number of valid instructions currently loaded
import icache_loader_pkg::*;

module icache_loader #(
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic [15:0]   pc,
  output logic [15:0]   raw_instruction,
  input  logic          program_complete,
  output logic          core_run,
  output logic          load_error,
  output logic [ADDR_W:0] loaded_len
);

  localparam logic [16:0] DEPTH_L = 17'(1) << ADDR_W;

  loader_state_e state;
  logic [7:0]    len_hi_r;
  logic [ADDR_W:0] len_r;
  logic [ADDR_W:0] addr_r;
  logic [7:0]    chk_r;
  logic [7:0]    hi_r;
  logic [ADDR_W:0] loaded_len_r;

  logic [15:0]   full_len;
  logic          len_ok;
  logic [ADDR_W:0] addr_inc;
  logic          mem_we;
  logic [15:0]   mem_rdata;
  logic          pc_in_range;

  assign full_len = {len_hi_r, rx_data};
  // Widen by one bit so lengths above DEPTH are rejected rather than wrapped.
  assign len_ok   = (full_len != 16'h0000) && ({1'b0, full_len} <= DEPTH_L);
  assign addr_inc = addr_r + 1'b1;
  assign mem_we   = (state == ST_DATA_LO) && rx_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_SYNC;
      len_hi_r     <= '0;
      len_r        <= '0;
      addr_r       <= '0;
      chk_r        <= '0;
      loaded_len_r <= '0;
    end else begin
      case (state)
        ST_SYNC: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state        <= ST_LEN_HI;
            loaded_len_r <= '0;
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            len_hi_r <= rx_data;
            state    <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (rx_valid) begin
            if (len_ok) begin
              len_r  <= full_len[ADDR_W:0];
              addr_r <= '0;
              chk_r  <= '0;
              state  <= ST_DATA_HI;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_DATA_HI: begin
          if (rx_valid) begin
            chk_r <= chk_r ^ rx_data;
            state <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (rx_valid) begin
            chk_r  <= chk_r ^ rx_data;
            addr_r <= addr_inc;
            state  <= (addr_inc == len_r) ? ST_CHK : ST_DATA_HI;
          end
        end
        ST_CHK: begin
          if (rx_valid) begin
            if (rx_data == chk_r) begin
              state        <= ST_RUN;
              loaded_len_r <= len_r;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        // Bytes are ignored while running; program_complete wins over any byte.
        ST_RUN: begin
          if (program_complete) state <= ST_SYNC;
        end
        ST_ERR: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state        <= ST_LEN_HI;
            loaded_len_r <= '0;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

  // High byte is pure data held for the following DATA_LO write.
  always_ff @(posedge clk) begin
    if (state == ST_DATA_HI && rx_valid) hi_r <= rx_data;
  end

  icache_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr_r[ADDR_W-1:0]),
    .wdata ({hi_r, rx_data}),
    .raddr (pc[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  // Full 16-bit compare so pc >= DEPTH never aliases into memory.
  assign pc_in_range     = pc < 16'(loaded_len_r);
  assign raw_instruction = pc_in_range ? mem_rdata : 16'h0000;
  assign core_run        = (state == ST_RUN);
  assign load_error      = (state == ST_ERR);
  assign loaded_len      = loaded_len_r;

endmodule
